mult_leak_sequencer: RTL and testbench
======================================

// Module: mult_leak_sequencer
// PURPOSE
//  Sequences one timing-leak measurement on two constant-time multiplier copies.
//  - Accepts an operand-pair request and launches both copies with a single shared start pulse.
//  - Counts the cycles until each copy asserts its done.
//  - Reports per-copy latency, their difference, and a leak/timeout verdict.
//  - Sits between the test-vector source and the two-copy multiplier tester; owns all start/done sequencing.
// PARAMETERS
//  WIDTH    32    operand width of each multiplier copy
//  CNT_W    16    cycle-counter width; must satisfy TIMEOUT < 2**CNT_W
//  TIMEOUT  1024  max RUN cycles before a copy is declared hung
// PORTS
//  clk         in   1      rising-edge clock
//  rst         in   1      asynchronous, active-high reset
//  req_valid   in   1      operand request valid
//  req_ready   out  1      high only in IDLE (combinational from state)
//  op_a1/op_b1 in   WIDTH  multiplier/multiplicand, copy one
//  op_a2/op_b2 in   WIDTH  multiplier/multiplicand, copy two
//  mult_start  out  1      one-cycle start pulse to both copies
//  mult_a1/b1  out  WIDTH  registered operands, copy one; stable from LAUNCH through REPORT
//  mult_a2/b2  out  WIDTH  registered operands, copy two; stable from LAUNCH through REPORT
//  done_one    in   1      product-done from copy one
//  done_two    in   1      product-done from copy two
//  res_valid   out  1      result valid; held until res_ready
//  res_ready   in   1      result consumer ready
//  cycles_one  out  CNT_W  RUN-cycle index of copy-one done
//  cycles_two  out  CNT_W  RUN-cycle index of copy-two done
//  delta       out  CNT_W  |cycles_one - cycles_two|
//  leak        out  1      latency mismatch detected
//  timeout     out  1      at least one copy missed TIMEOUT
//  busy        out  1      state != IDLE
// BEHAVIOUR
//  Reset
//   - All registered outputs, counter, captures and edge registers clear to 0; state=IDLE.
//   - Consequently req_ready=1.
//   - Reset asserted mid-RUN aborts immediately; no result is emitted.
//  FSM: IDLE -> LAUNCH -> RUN -> REPORT -> IDLE
//   - IDLE: on req_valid (req_ready=1), latch all four operands -> LAUNCH.
//   - LAUNCH: mult_start=1 for exactly this cycle; counter<=0; sticky flags cleared -> RUN.
//   - RUN: counter increments each cycle; the first RUN cycle has count 1.
//     - A copy is captured on a rising edge of its done (done & ~done_q).
//     - done_q is registered every cycle in all states, so a level left high from a prior run is never captured.
//     - Captured value = current count; only the first edge per run counts (sticky).
//     - Exit to REPORT once both captured, or when count==TIMEOUT.
//     - Edges in the TIMEOUT cycle itself are captured.
//   - REPORT: res_valid=1; results update on entry and are held stable.
//     - req_valid is ignored.
//     - Leave for IDLE on res_ready.
//     - Results persist after exit until the next REPORT.
//  Verdict
//   - An uncaptured copy reports cycles=TIMEOUT.
//   - timeout=1 if either copy was uncaptured.
//   - leak=1 if cycles differ, or if exactly one copy was uncaptured.
//   - Both uncaptured: leak=0, timeout=1.
//   - Simultaneous done edges give equal counts: leak=0, delta=0.
//   - delta is unsigned; the counter saturates and never wraps.
// STRUCTURE
//  - Package mult_leak_pkg holds:
//    - the state typedef enum {IDLE, LAUNCH, RUN, REPORT};
//    - default WIDTH/CNT_W/TIMEOUT constants.
//  - Sub-module mult_done_capture is instantiated twice, one per copy.
//    - It contains the edge detector, sticky flag and CNT_W capture register.
// TESTING
//  1. rst pulsed in RUN cycle 3 -> mult_start=0, res_valid=0, busy=0, req_ready=1; no REPORT follows.
//  2. Both done edges at RUN cycle 8 -> cycles_one=cycles_two=8, delta=0, leak=0, timeout=0.
//  3. done_one at cycle 5, done_two at cycle 9 -> delta=4, leak=1; REPORT entered the cycle after cycle 9.
//  4. TIMEOUT=16, done_two never asserts, done_one at 7 -> REPORT after cycle 16; cycles_two=16, timeout=1, leak=1.
//  5. res_ready low 3 cycles in REPORT, with req_valid high -> outputs stable, req_ready=0, no new launch.
//  6. Back-to-back runs with done_one held high across LAUNCH -> no capture until done_one falls and rises again.

Source files
------------

// File: rtl/mult_leak_pkg.sv
// Shared types and default sizing for the two-copy multiplier timing-leak sequencer.
package mult_leak_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    RUN    = 2'd2,
    REPORT = 2'd3
  } state_t;

  localparam int DEF_WIDTH   = 32;
  localparam int DEF_CNT_W   = 16;
  localparam int DEF_TIMEOUT = 1024;

endpackage

// File: rtl/mult_done_capture.sv
// Per-copy done tracker: rising-edge detect, sticky first-edge flag and captured cycle count.
module mult_done_capture #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             run,
  input  logic             done,
  input  logic [CNT_W-1:0] count,
  output logic             captured_next,
  output logic [CNT_W-1:0] cycles_next
);

  logic             done_q;
  logic             captured;
  logic [CNT_W-1:0] cycles;
  logic             hit;

  // done_q tracks every cycle so a level carried over from a previous run never looks like an edge
  assign hit           = run & done & ~done_q & ~captured;
  assign captured_next = captured | hit;
  assign cycles_next   = hit ? count : cycles;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_q   <= 1'b0;
      captured <= 1'b0;
      cycles   <= '0;
    end else begin
      done_q <= done;
      if (clear) begin
        captured <= 1'b0;
        cycles   <= '0;
      end else begin
        captured <= captured_next;
        cycles   <= cycles_next;
      end
    end
  end

endmodule

// File: rtl/mult_leak_sequencer.sv
// Launches two multiplier copies with one start pulse, times their done edges and
// reports per-copy latency, the latency difference and a leak/timeout verdict.
module mult_leak_sequencer
  import mult_leak_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int CNT_W   = DEF_CNT_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] op_a1,
  input  logic [WIDTH-1:0] op_b1,
  input  logic [WIDTH-1:0] op_a2,
  input  logic [WIDTH-1:0] op_b2,
  output logic             mult_start,
  output logic [WIDTH-1:0] mult_a1,
  output logic [WIDTH-1:0] mult_b1,
  output logic [WIDTH-1:0] mult_a2,
  output logic [WIDTH-1:0] mult_b2,
  input  logic             done_one,
  input  logic             done_two,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [CNT_W-1:0] cycles_one,
  output logic [CNT_W-1:0] cycles_two,
  output logic [CNT_W-1:0] delta,
  output logic             leak,
  output logic             timeout,
  output logic             busy
);

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic [CNT_W-1:0] abs_diff(input logic [CNT_W-1:0] x,
                                                input logic [CNT_W-1:0] y);
    return (x > y) ? x - y : y - x;
  endfunction

  state_t           state;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] run_cnt;
  logic             cap1_n, cap2_n;
  logic [CNT_W-1:0] cyc1_n, cyc2_n;
  logic [CNT_W-1:0] v1, v2;
  logic             at_limit;
  logic             finish_run;

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  // run_cnt is the index of the current RUN cycle (first RUN cycle reads 1)
  assign run_cnt    = sat_inc(cnt_q);
  assign at_limit   = (run_cnt == TIMEOUT_C);
  assign finish_run = (cap1_n & cap2_n) | at_limit;

  assign v1 = cap1_n ? cyc1_n : TIMEOUT_C;
  assign v2 = cap2_n ? cyc2_n : TIMEOUT_C;

  mult_done_capture #(.CNT_W(CNT_W)) u_cap_one (
    .clk           (clk),
    .rst           (rst),
    .clear         (state == LAUNCH),
    .run           (state == RUN),
    .done          (done_one),
    .count         (run_cnt),
    .captured_next (cap1_n),
    .cycles_next   (cyc1_n)
  );

  mult_done_capture #(.CNT_W(CNT_W)) u_cap_two (
    .clk           (clk),
    .rst           (rst),
    .clear         (state == LAUNCH),
    .run           (state == RUN),
    .done          (done_two),
    .count         (run_cnt),
    .captured_next (cap2_n),
    .cycles_next   (cyc2_n)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt_q      <= '0;
      mult_start <= 1'b0;
      mult_a1    <= '0;
      mult_b1    <= '0;
      mult_a2    <= '0;
      mult_b2    <= '0;
      res_valid  <= 1'b0;
      cycles_one <= '0;
      cycles_two <= '0;
      delta      <= '0;
      leak       <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      mult_start <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            mult_a1    <= op_a1;
            mult_b1    <= op_b1;
            mult_a2    <= op_a2;
            mult_b2    <= op_b2;
            mult_start <= 1'b1;
            state      <= LAUNCH;
          end
        end
        LAUNCH: begin
          cnt_q <= '0;
          state <= RUN;
        end
        RUN: begin
          cnt_q <= run_cnt;
          // results load from the capture next-values so an edge in the final cycle counts
          if (finish_run) begin
            cycles_one <= v1;
            cycles_two <= v2;
            delta      <= abs_diff(v1, v2);
            leak       <= (v1 != v2) | (cap1_n ^ cap2_n);
            timeout    <= ~(cap1_n & cap2_n);
            res_valid  <= 1'b1;
            state      <= REPORT;
          end
        end
        REPORT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_leak_sequencer.sv
// Scoreboard bench for mult_leak_sequencer with TIMEOUT=16 and bench-driven done levels.
module tb_mult_leak_sequencer;

  localparam int W  = 32;
  localparam int CW = 16;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [W-1:0]  op_a1 = '0, op_b1 = '0, op_a2 = '0, op_b2 = '0;
  logic          mult_start;
  logic [W-1:0]  mult_a1, mult_b1, mult_a2, mult_b2;
  logic          done_one = 1'b0, done_two = 1'b0;
  logic          res_valid;
  logic          res_ready = 1'b1;
  logic [CW-1:0] cycles_one, cycles_two, delta;
  logic          leak, timeout, busy;

  typedef struct {
    logic [CW-1:0] c1;
    logic [CW-1:0] c2;
    logic [CW-1:0] delta;
    logic          leak;
    logic          timeout;
    int            rep;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  mult_leak_sequencer #(.WIDTH(W), .CNT_W(CW), .TIMEOUT(TO)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .op_a1      (op_a1),
    .op_b1      (op_b1),
    .op_a2      (op_a2),
    .op_b2      (op_b2),
    .mult_start (mult_start),
    .mult_a1    (mult_a1),
    .mult_b1    (mult_b1),
    .mult_a2    (mult_a2),
    .mult_b2    (mult_b2),
    .done_one   (done_one),
    .done_two   (done_two),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .cycles_one (cycles_one),
    .cycles_two (cycles_two),
    .delta      (delta),
    .leak       (leak),
    .timeout    (timeout),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish required finish");
    $fatal(1);
  end

  // One measurement: d1/d2 = RUN cycle of the done rising edge (0 = never),
  // pre1 = done_one held high through LAUNCH and RUN cycles below pre1, stall = REPORT cycles with res_ready low.
  task automatic do_run(input string name, input int d1, input int d2, input int pre1, input int stall);
    exp_t e, got_e;
    logic [W-1:0] a1, b1, a2, b2;
    bit c1ok, c2ok;
    int got;
    a1 = $urandom; b1 = $urandom; a2 = $urandom; b2 = $urandom;
    c1ok = (d1 > 0) && (d1 <= TO);
    c2ok = (d2 > 0) && (d2 <= TO);
    e.c1 = c1ok ? CW'(d1) : CW'(TO);
    e.c2 = c2ok ? CW'(d2) : CW'(TO);
    e.delta = (e.c1 > e.c2) ? e.c1 - e.c2 : e.c2 - e.c1;
    e.leak = (e.c1 != e.c2) || (c1ok != c2ok);
    e.timeout = !(c1ok && c2ok);
    e.rep = (c1ok && c2ok) ? ((d1 > d2) ? d1 : d2) : TO;
    sb.push_back(e);

    @(negedge clk);
    n_checks++;
    if (req_ready !== 1'b1) begin n_fail++; $display("FAIL %s req_ready_idle: got %b required 1", name, req_ready); end
    req_valid = 1'b1;
    res_ready = (stall == 0);
    op_a1 = a1; op_b1 = b1; op_a2 = a2; op_b2 = b2;
    done_one = (pre1 > 0);
    done_two = 1'b0;

    @(negedge clk);
    req_valid = 1'b0;
    op_a1 = $urandom; op_b1 = $urandom; op_a2 = $urandom; op_b2 = $urandom;
    n_checks++;
    if (mult_start !== 1'b1) begin n_fail++; $display("FAIL %s start_pulse: got %b required 1", name, mult_start); end
    n_checks++;
    if ({mult_a1, mult_b1, mult_a2, mult_b2} !== {a1, b1, a2, b2}) begin
      n_fail++; $display("FAIL %s operands_latched: got %h %h %h %h required %h %h %h %h", name, mult_a1, mult_b1, mult_a2, mult_b2, a1, b1, a2, b2);
    end
    n_checks++;
    if (busy !== 1'b1 || req_ready !== 1'b0) begin n_fail++; $display("FAIL %s busy_launch: got busy=%b ready=%b required busy=1 ready=0", name, busy, req_ready); end

    got = -1;
    for (int k = 1; k <= TO + 2; k++) begin
      @(negedge clk);
      if (res_valid === 1'b1) begin
        got = k - 1;
        break;
      end
      if (k == 1) begin
        n_checks++;
        if (mult_start !== 1'b0) begin n_fail++; $display("FAIL %s start_one_cycle: got %b required 0", name, mult_start); end
      end
      done_one = (k < pre1) || (d1 > 0 && k >= d1);
      done_two = (d2 > 0 && k >= d2);
    end

    n_checks++;
    if (got != e.rep) begin n_fail++; $display("FAIL %s report_cycle: got %0d required %0d", name, got, e.rep); end
    got_e = sb.pop_front();
    if (got < 0) begin
      res_ready = 1'b1;
      return;
    end

    n_checks++;
    if ({cycles_one, cycles_two, delta, leak, timeout} !== {got_e.c1, got_e.c2, got_e.delta, got_e.leak, got_e.timeout}) begin
      n_fail++;
      $display("FAIL %s result: got c1=%0d c2=%0d d=%0d leak=%b to=%b required c1=%0d c2=%0d d=%0d leak=%b to=%b",
               name, cycles_one, cycles_two, delta, leak, timeout, got_e.c1, got_e.c2, got_e.delta, got_e.leak, got_e.timeout);
    end
    n_checks++;
    if ({mult_a1, mult_b1, mult_a2, mult_b2} !== {a1, b1, a2, b2}) begin
      n_fail++; $display("FAIL %s operands_held: got %h %h %h %h required %h %h %h %h", name, mult_a1, mult_b1, mult_a2, mult_b2, a1, b1, a2, b2);
    end

    for (int i = 0; i < stall; i++) begin
      req_valid = 1'b1;
      @(negedge clk);
      n_checks++;
      if (res_valid !== 1'b1 || req_ready !== 1'b0 || mult_start !== 1'b0 || busy !== 1'b1) begin
        n_fail++; $display("FAIL %s stall_ctrl: got vld=%b rdy=%b start=%b busy=%b required 1 0 0 1", name, res_valid, req_ready, mult_start, busy);
      end
      n_checks++;
      if ({cycles_one, cycles_two, delta, leak, timeout} !== {got_e.c1, got_e.c2, got_e.delta, got_e.leak, got_e.timeout}) begin
        n_fail++; $display("FAIL %s stall_stable: got c1=%0d c2=%0d d=%0d required c1=%0d c2=%0d d=%0d", name, cycles_one, cycles_two, delta, got_e.c1, got_e.c2, got_e.delta);
      end
    end

    req_valid = 1'b0;
    res_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (res_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1) begin
      n_fail++; $display("FAIL %s back_to_idle: got vld=%b busy=%b rdy=%b required 0 0 1", name, res_valid, busy, req_ready);
    end
    n_checks++;
    if ({cycles_one, cycles_two, leak} !== {got_e.c1, got_e.c2, got_e.leak}) begin
      n_fail++; $display("FAIL %s result_persist: got c1=%0d c2=%0d leak=%b required c1=%0d c2=%0d leak=%b", name, cycles_one, cycles_two, leak, got_e.c1, got_e.c2, got_e.leak);
    end
    done_two = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if ({mult_start, res_valid, busy, leak, timeout} !== 5'b0 || req_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_ctrl: got start=%b vld=%b busy=%b leak=%b to=%b rdy=%b required 0 0 0 0 0 1", mult_start, res_valid, busy, leak, timeout, req_ready);
    end
    n_checks++;
    if ({cycles_one, cycles_two, delta} !== '0 || {mult_a1, mult_b1, mult_a2, mult_b2} !== '0) begin
      n_fail++; $display("FAIL reset_data: got c1=%0d c2=%0d d=%0d a1=%h required all zero", cycles_one, cycles_two, delta, mult_a1);
    end
    rst = 1'b0;
  endtask

  task automatic test_simultaneous();   do_run("simultaneous", 8, 8, 0, 0);  endtask
  task automatic test_skew();           do_run("skew", 5, 9, 0, 0);          endtask
  task automatic test_timeout();        do_run("timeout_one", 7, 0, 0, 0);   endtask
  task automatic test_timeout_edge();   do_run("edge_at_limit", 16, 3, 0, 0); endtask
  task automatic test_both_hung();      do_run("both_hung", 0, 0, 0, 0);     endtask
  task automatic test_report_stall();   do_run("report_stall", 4, 6, 0, 3);  endtask

  task automatic test_back_to_back();
    do_run("b2b_first", 2, 4, 0, 0);
    do_run("b2b_held", 6, 2, 3, 0);
  endtask

  task automatic test_reset_abort();
    bit saw;
    @(negedge clk);
    req_valid = 1'b1;
    op_a1 = $urandom; op_b1 = $urandom; op_a2 = $urandom; op_b2 = $urandom;
    done_one = 1'b0; done_two = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++;
    if (mult_start !== 1'b0 || res_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1) begin
      n_fail++; $display("FAIL abort_ctrl: got start=%b vld=%b busy=%b rdy=%b required 0 0 0 1", mult_start, res_valid, busy, req_ready);
    end
    n_checks++;
    if ({cycles_one, cycles_two, delta, leak, timeout} !== '0) begin
      n_fail++; $display("FAIL abort_results_cleared: got c1=%0d c2=%0d d=%0d leak=%b to=%b required all zero", cycles_one, cycles_two, delta, leak, timeout);
    end
    @(negedge clk);
    rst = 1'b0;
    done_one = 1'b1;
    done_two = 1'b1;
    saw = 1'b0;
    repeat (TO + 4) begin
      @(negedge clk);
      if (res_valid !== 1'b0 || busy !== 1'b0) saw = 1'b1;
    end
    n_checks++;
    if (saw) begin n_fail++; $display("FAIL abort_no_report: got activity=1 required 0"); end
    done_one = 1'b0;
    done_two = 1'b0;
  endtask

  initial begin
    test_reset();
    test_simultaneous();
    test_skew();
    test_timeout();
    test_timeout_edge();
    test_both_hung();
    test_report_stall();
    test_back_to_back();
    test_reset_abort();
    n_checks++;
    if (sb.size() != 0) begin n_fail++; $display("FAIL scoreboard_drain: got %0d left required 0", sb.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
